// File: rtl/window_gen.sv
// window_gen: streams a raster image from a pop-style FIFO and emits every full 3x3 window.
// Optional feature: define WINDOW_GEN_STATS_EN to add the saturating win_count output.
module window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    fifo_empty,
  output logic                    fifo_en,
  output logic                    fifo_push_pop,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    busy,
  output logic                    frame_done
`ifdef WINDOW_GEN_STATS_EN
  ,
  output logic [15:0]             win_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_e;

  state_e                  state_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic                    win_valid_q;
  logic                    busy_q;
  logic                    frame_done_q;
  logic [9*DATA_WIDTH-1:0] win_data_q;
  logic [9*DATA_WIDTH-1:0] win_data_d;

  // lb0_q holds the previous row, lb1_q the row above that.
  logic [DATA_WIDTH-1:0]   lb0_q [IMG_W];
  logic [DATA_WIDTH-1:0]   lb1_q [IMG_W];
  // Two left-hand window columns; the right-hand column is the one arriving this cycle.
  logic [DATA_WIDTH-1:0]   hist_q [3][2];
  logic [DATA_WIDTH-1:0]   col_new [3];

  logic pop;
  logic emit;
  logic last_pix;
  logic fill_done;

  assign pop       = reset && (state_q == FILL || state_q == STREAM) && !fifo_empty &&
                     (!win_valid_q || win_ready);
  assign emit      = pop && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign fill_done = (row_q == ROW_TWO) && (col_q == COL_TWO);

  assign col_new[0] = lb1_q[col_q];
  assign col_new[1] = lb0_q[col_q];
  assign col_new[2] = fifo_data;

  // Element 3*r+c, so the bottom-right pixel lands in the most significant slot.
  assign win_data_d = {col_new[2], hist_q[2][1], hist_q[2][0],
                       col_new[1], hist_q[1][1], hist_q[1][0],
                       col_new[0], hist_q[0][1], hist_q[0][0]};

  // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (emit) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_data_d;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL, STREAM: begin
          if (pop) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (last_pix) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else if (fill_done) begin
              state_q <= STREAM;
            end
          end
        end
        DONE: begin
          frame_done_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the line buffers are cleared by reset too, so a restarted frame never sees stale pixels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        hist_q[r][0] <= '0;
        hist_q[r][1] <= '0;
      end
    end else if (pop) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= fifo_data;
      for (int r = 0; r < 3; r++) begin
        hist_q[r][0] <= hist_q[r][1];
        hist_q[r][1] <= col_new[r];
      end
    end
  end

`ifdef WINDOW_GEN_STATS_EN
  logic [15:0] win_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_count_q <= '0;
    end else if (state_q == IDLE && start) begin
      win_count_q <= '0;
    end else if (win_valid_q && win_ready && win_count_q != 16'hFFFF) begin
      win_count_q <= win_count_q + 16'd1;
    end
  end

  assign win_count = win_count_q;
`endif

  assign fifo_en       = pop;
  assign fifo_push_pop = 1'b0;
  assign win_data      = win_data_q;
  assign win_valid     = win_valid_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen: a 4x4 instance and an 8x3 instance share one FIFO model.
module tb_window_gen;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          sel;
  logic          start;
  logic          fifo_empty;
  logic          win_ready;
  logic [DW-1:0] fifo_data;

  logic            en_a, en_b, pp_a, pp_b, wv_a, wv_b, busy_a, busy_b, fd_a, fd_b;
  logic [9*DW-1:0] wd_a, wd_b;
  logic            fifo_en, fifo_push_pop, win_valid, busy, frame_done;
  logic [9*DW-1:0] win_data;
`ifdef WINDOW_GEN_STATS_EN
  logic [15:0]     wc_a, wc_b, win_count;
`endif

  window_gen #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .reset(reset), .start(start && !sel), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty || sel), .fifo_en(en_a), .fifo_push_pop(pp_a),
    .win_data(wd_a), .win_valid(wv_a), .win_ready(win_ready), .busy(busy_a),
    .frame_done(fd_a)
`ifdef WINDOW_GEN_STATS_EN
    , .win_count(wc_a)
`endif
  );

  window_gen #(.DATA_WIDTH(DW), .IMG_W(8), .IMG_H(3)) dut_b (
    .clk(clk), .reset(reset), .start(start && sel), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty || !sel), .fifo_en(en_b), .fifo_push_pop(pp_b),
    .win_data(wd_b), .win_valid(wv_b), .win_ready(win_ready), .busy(busy_b),
    .frame_done(fd_b)
`ifdef WINDOW_GEN_STATS_EN
    , .win_count(wc_b)
`endif
  );

  assign fifo_en       = sel ? en_b   : en_a;
  assign fifo_push_pop = sel ? pp_b   : pp_a;
  assign win_data      = sel ? wd_b   : wd_a;
  assign win_valid     = sel ? wv_b   : wv_a;
  assign busy          = sel ? busy_b : busy_a;
  assign frame_done    = sel ? fd_b   : fd_a;
`ifdef WINDOW_GEN_STATS_EN
  assign win_count     = sel ? wc_b   : wc_a;
`endif

  int              n_checks;
  int              n_fail;
  int              img_w;
  int              img_h;
  logic [DW-1:0]   pix_q[$];
  logic [9*DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pixel values equal their raster index, so window (r,c) is fully determined by its position.
  function automatic logic [9*DW-1:0] exp_win(input int r, input int c, input int w);
    logic [9*DW-1:0] v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[DW*(3*i+j) +: DW] = DW'((r - 2 + i) * w + (c - 2 + j));
    return v;
  endfunction

  // mode 0 plain, 1 ready stall, 2 FIFO underrun, 3 mid-frame reset, 4 start while busy
  task automatic run_frame(input int mode);
    int  n_acc, n_win, n_done, last_hs, done_cyc, stall_cnt, empty_cnt;
    bit  stalled_once, empty_done, acc;
    logic [9*DW-1:0] got_win;
    pix_q.delete();
    exp_q.delete();
    for (int i = 0; i < img_w * img_h; i++) pix_q.push_back(DW'(i));
    n_acc = 0; n_win = 0; n_done = 0; last_hs = -10; done_cyc = 0;
    stall_cnt = 0; empty_cnt = 0; stalled_once = 0; empty_done = 0;

    @(negedge clk);
    start = 1'b1; win_ready = 1'b1; fifo_empty = 1'b0; fifo_data = pix_q[0];
    @(posedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (frame_done) begin
        n_done++;
        if (n_done == 1) begin
          done_cyc = cyc;
          check("done_latency", cyc - last_hs, 1);
        end
      end
      if (n_done > 0 && cyc > done_cyc + 3) break;
      if (mode == 1 && !stalled_once && win_valid) begin
        stall_cnt    = 5;
        stalled_once = 1;
      end
      win_ready  = (stall_cnt == 0);
      fifo_empty = (pix_q.size() == 0) || (empty_cnt > 0);
      fifo_data  = (pix_q.size() > 0) ? pix_q[0] : '0;
      start      = (mode == 4) && (cyc == 8 || cyc == 15);
      #1;
      if (start) check("busy_at_start", busy, 1);
      if (stall_cnt > 0) begin
        check("stall_fifo_en", fifo_en, 0);
        check("stall_valid", win_valid, 1);
        check("stall_hold", win_data, exp_q.size() > 0 ? exp_q[0] : '0);
        stall_cnt--;
      end
      if (empty_cnt > 0) begin
        check("empty_fifo_en", fifo_en, 0);
        empty_cnt--;
      end
      if (win_valid && win_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          got_win = exp_q.pop_front();
          check("window", win_data, got_win);
        end
        if (n_win == 0) check("busy_mid", busy, 1);
        n_win++;
        last_hs = cyc;
      end
      acc = fifo_en;
      if (acc && (n_acc / img_w) >= 2 && (n_acc % img_w) >= 2)
        exp_q.push_back(exp_win(n_acc / img_w, n_acc % img_w, img_w));
      @(posedge clk);
      if (acc) begin
        void'(pix_q.pop_front());
        n_acc++;
      end
      if (mode == 2 && n_acc == 7 && !empty_done) begin
        empty_cnt  = 3;
        empty_done = 1;
      end
      if (mode == 3 && n_acc == 10) begin
        @(negedge clk);
        check("busy_pre_rst", busy, 1);
        reset = 1'b0; start = 1'b0; fifo_empty = 1'b0; win_ready = 1'b1;
        #1 check("rst_fifo_en", fifo_en, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_win_valid", win_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_win_data", win_data, 0);
        check("rst_idle_no_pop", fifo_en, 0);
        return;
      end
    end
    check("frame_done_cnt", n_done, 1);
    check("win_total", n_win, (img_w - 2) * (img_h - 2));
    check("sb_empty", exp_q.size(), 0);
    check("busy_end", busy, 0);
`ifdef WINDOW_GEN_STATS_EN
    check("win_count", win_count, (img_w - 2) * (img_h - 2));
`endif
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; sel = 1'b0; start = 1'b0; fifo_empty = 1'b0; fifo_data = '0; win_ready = 1'b1;
    img_w = 4; img_h = 4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_a_fifo_en", fifo_en, 0);
    check("rst_a_valid", win_valid, 0);
    check("rst_a_busy", busy, 0);
    check("rst_a_done", frame_done, 0);
    check("rst_a_data", win_data, 0);
    check("rst_a_push_pop", fifo_push_pop, 0);
    sel = 1'b1;
    #1;
    check("rst_b_fifo_en", fifo_en, 0);
    check("rst_b_valid", win_valid, 0);
    check("rst_b_data", win_data, 0);
    sel = 1'b0;
    reset = 1'b1;
    fifo_empty = 1'b1;

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);
    run_frame(4);

    sel = 1'b1; img_w = 8; img_h = 3;
    run_frame(0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
